jackal_ym3012: RTL and testbench

Serial-to-parallel DAC stage for the Jackal YM2151 audio path, modelling the YM3012 floating-point DAC. It deserializes the YM2151 serial output, converts each 13-bit mantissa/exponent word to 16-bit signed linear PCM, and holds separate left and right samples. Its `left` and `right` outputs drive the two 16-bit inputs of the Jackal low-pass filter stage directly downstream.

---
 rtl/jackal_ym3012.sv | 133 +++++++++++++
 tb/tb_jackal_ym3012.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/jackal_ym3012.sv
// jackal_ym3012: YM3012-style serial floating-point DAC front end.
// Deserializes the YM2151 serial stream (LSB first, sampled on cen), converts
// each 13-bit {exponent[2:0], mantissa[9:0]} word to 16-bit signed PCM and
// holds it per channel on the falling edge of the matching sample-hold strobe.
//
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   cen             - YM2151 phi1 enable; so is shifted in only when high
//   so              - serial data, LSB first
//   sh1, sh2        - left / right sample-hold strobes (falling edge latches)
//   left, right     - held signed PCM samples
//   left_valid,
//   right_valid     - one-clk pulse coincident with a channel update
//   frame_err       - sticky: a strobe arrived before 13 bits were shifted in
module jackal_ym3012 #(
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cen,
    input  logic               so,
    input  logic               sh1,
    input  logic               sh2,
    output logic signed [15:0] left,
    output logic signed [15:0] right,
    output logic               left_valid,
    output logic               right_valid,
    output logic               frame_err
);

    localparam int unsigned WORD_BITS = 13;
    localparam int unsigned CNT_W     = 5;
    // Saturation bound: 31 for any realistic frame, never below one word.
    localparam int unsigned CNT_MAX   = (2 * FRAME_BITS - 1 > 31) ? 31 : (2 * FRAME_BITS - 1);

    logic [WORD_BITS-1:0] sr, sr_next;
    logic [CNT_W-1:0]     cnt, cnt_inc;
    logic                 sh1_d, sh2_d;
    logic                 fall1, fall2, any_fall, word_ok;

    logic [9:0]           m;
    logic [2:0]           e;
    logic signed [9:0]    s10;
    logic signed [15:0]   ext, conv;

    // Edge-cycle pipeline stage between detection and the output registers
    logic                 pend_l, pend_r, pend_err;
    logic signed [15:0]   pend_word;

    // Next-cycle shift/count values, so a bit arriving on the edge cycle counts
    always_comb begin
        sr_next  = sr;
        cnt_inc  = cnt;
        if (cen) begin
            sr_next = {so, sr[WORD_BITS-1:1]};
            if (cnt != CNT_W'(CNT_MAX)) begin
                cnt_inc = cnt + CNT_W'(1);
            end
        end
        fall1    = sh1_d & ~sh1;
        fall2    = sh2_d & ~sh2;
        any_fall = fall1 | fall2;
        word_ok  = (cnt_inc >= CNT_W'(WORD_BITS));
    end

    // Floating-point to linear: offset-binary mantissa, shift by exponent-1, e=0 mutes
    always_comb begin
        m    = sr_next[9:0];
        e    = sr_next[12:10];
        s10  = {~m[9], m[8:0]};
        ext  = 16'(s10);
        conv = '0;
        if (e != 3'd0) begin
            conv = ext <<< 3'(e - 3'd1);
        end
    end

    // Shift register, counter and strobe history
    always_ff @(posedge clk) begin
        if (reset) begin
            sr    <= '0;
            cnt   <= '0;
            sh1_d <= 1'b0;
            sh2_d <= 1'b0;
        end else begin
            sr    <= sr_next;
            cnt   <= any_fall ? '0 : cnt_inc;
            sh1_d <= sh1;
            sh2_d <= sh2;
        end
    end

    // Capture the converted word on the edge cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_l    <= 1'b0;
            pend_r    <= 1'b0;
            pend_err  <= 1'b0;
            pend_word <= '0;
        end else begin
            pend_l    <= fall1 & word_ok;
            pend_r    <= fall2 & word_ok;
            pend_err  <= any_fall & ~word_ok;
            if (any_fall & word_ok) begin
                pend_word <= conv;
            end
        end
    end

    // Held outputs, valid pulses and sticky frame error
    always_ff @(posedge clk) begin
        if (reset) begin
            left        <= '0;
            right       <= '0;
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            left_valid  <= pend_l;
            right_valid <= pend_r;
            if (pend_l) begin
                left <= pend_word;
            end
            if (pend_r) begin
                right <= pend_word;
            end
            if (pend_err) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jackal_ym3012.sv
// tb_jackal_ym3012: directed self-checking bench for jackal_ym3012.
// Frames are generated LSB first with leading zero dummies; strobes drop just
// after a clock edge and the response is checked 1, 2 and 3 clks later.
`timescale 1ns/1ps
module tb_jackal_ym3012;

    localparam int unsigned FRAME_BITS = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               cen;
    logic               so;
    logic               sh1;
    logic               sh2;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               left_valid;
    logic               right_valid;
    logic               frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    jackal_ym3012 #(.FRAME_BITS(FRAME_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .cen         (cen),
        .so          (so),
        .sh1         (sh1),
        .sh2         (sh2),
        .left        (left),
        .right       (right),
        .left_valid  (left_valid),
        .right_valid (right_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        so  = b;
        cen = 1'b1;
        tick();
        cen = 1'b0;
        tick();
    endtask

    // Full frame: FRAME_BITS-13 zero dummies then the 13-bit word, LSB first
    task automatic send_frame(input logic [2:0] e, input logic [9:0] m);
        logic [31:0] fr;
        fr = 32'({e, m}) << (FRAME_BITS - 13);
        for (int i = 0; i < int'(FRAME_BITS); i++) send_bit(fr[i]);
    endtask

    // Only the last n bits of the word (n <= 13)
    task automatic send_tail(input logic [2:0] e, input logic [9:0] m, input int n);
        logic [12:0] w;
        w = {e, m};
        for (int i = 13 - n; i < 13; i++) send_bit(w[i]);
    endtask

    task automatic strobe(input string tag, input logic s1, input logic s2,
                          input logic [15:0] exp_l, input logic [15:0] exp_r,
                          input logic exp_v);
        if (s1) sh1 = 1'b1;
        if (s2) sh2 = 1'b1;
        tick();
        tick();
        sh1 = 1'b0;
        sh2 = 1'b0;
        tick();
        check({tag, " lv@1"}, 16'(left_valid), 16'(1'b0));
        check({tag, " rv@1"}, 16'(right_valid), 16'(1'b0));
        tick();
        check({tag, " lv@2"}, 16'(left_valid), 16'(s1 & exp_v));
        check({tag, " rv@2"}, 16'(right_valid), 16'(s2 & exp_v));
        check({tag, " left"}, left, exp_l);
        check({tag, " right"}, right, exp_r);
        tick();
        check({tag, " lv@3"}, 16'(left_valid), 16'(1'b0));
        check({tag, " rv@3"}, 16'(right_valid), 16'(1'b0));
    endtask

    initial begin
        reset = 1'b1;
        cen   = 1'b0;
        so    = 1'b0;
        sh1   = 1'b0;
        sh2   = 1'b0;
        tick();
        tick();
        tick();
        check("rst left", left, 16'h0000);
        check("rst right", right, 16'h0000);
        check("rst lv", 16'(left_valid), 16'(1'b0));
        check("rst rv", 16'(right_valid), 16'(1'b0));
        check("rst ferr", 16'(frame_err), 16'(1'b0));
        reset = 1'b0;
        // sh1/sh2 held low across reset must not look like an edge
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post-rst lv", 16'(left_valid), 16'(1'b0));
            check("post-rst rv", 16'(right_valid), 16'(1'b0));
        end

        send_frame(3'd7, 10'h3FF);
        strobe("fs pos", 1'b1, 1'b0, 16'h7FC0, 16'h0000, 1'b1);

        send_frame(3'd7, 10'h000);
        strobe("fs neg", 1'b0, 1'b1, 16'h7FC0, 16'h8000, 1'b1);

        send_frame(3'd3, 10'h280);
        strobe("e3", 1'b1, 1'b0, 16'h0200, 16'h8000, 1'b1);

        send_frame(3'd0, 10'h280);
        strobe("mute", 1'b1, 1'b0, 16'h0000, 16'h8000, 1'b1);

        send_frame(3'd7, 10'h200);
        strobe("zero", 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1);

        send_frame(3'd1, 10'h17F);
        strobe("e1 neg", 1'b1, 1'b0, 16'hFF7F, 16'h0000, 1'b1);

        send_frame(3'd2, 10'h240);
        strobe("both", 1'b1, 1'b1, 16'h0080, 16'h0080, 1'b1);
        check("ferr before short", 16'(frame_err), 16'(1'b0));

        send_tail(3'd7, 10'h3FF, 12);
        strobe("short", 1'b1, 1'b0, 16'h0080, 16'h0080, 1'b0);
        check("ferr short", 16'(frame_err), 16'(1'b1));

        send_frame(3'd7, 10'h3FF);
        strobe("after short", 1'b1, 1'b0, 16'h7FC0, 16'h0080, 1'b1);
        check("ferr sticky", 16'(frame_err), 16'(1'b1));

        // Reset in the middle of a frame discards partial bits and the error
        send_tail(3'd5, 10'h155, 8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid-rst ferr", 16'(frame_err), 16'(1'b0));
        check("mid-rst left", left, 16'h0000);
        send_tail(3'd7, 10'h3FF, 13);
        strobe("after rst", 1'b1, 1'b0, 16'h7FC0, 16'h0000, 1'b1);
        check("after rst ferr", 16'(frame_err), 16'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
